// File: rtl/sound_mixer_pkg.sv
`default_nettype none
// ==== sound_mixer_pkg: shared encodings for the mixer and its modulators (rev 1.0) ====
package sound_mixer_pkg;

  typedef enum logic {
    MODE_PWM = 1'b0,
    MODE_SDM = 1'b1
  } mode_e;

  // Config byte layout: vol in din[VW-1:0], pan bits directly above it
  localparam int CFG_PAN_R_OFS = 0;
  localparam int CFG_PAN_L_OFS = 1;

  localparam logic TAPE_LVL_MSB  = 1'b0;
  localparam logic TAPE_LVL_LSBS = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sound_mod.sv
`default_nettype none
// ==== sound_mod: one-side PWM / first-order sigma-delta modulator (rev 1.0) ====
module sound_mod
  import sound_mixer_pkg::*;
#(
  parameter int OW = 10
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [OW-1:0] val_i,
  input  logic          mode_i,
  input  logic [OW:0]   pctr_i,
  input  logic          clr_i,
  output logic          bit_o
);

  logic          phase_w;
  logic [OW-1:0] saw_w;
  logic [OW-1:0] tri_w;
  logic          pwm_w;
  logic          gte_w;
  logic [OW-1:0] sacc_q;
  logic [OW-1:0] sacc_d;

  // Triangle built from the saw so each half-period is symmetric around its centre
  assign phase_w = pctr_i[OW];
  assign saw_w   = pctr_i[OW-1:0];
  assign tri_w   = phase_w ? saw_w : ~saw_w;
  assign pwm_w   = (tri_w < val_i);

  assign gte_w  = (val_i >= sacc_q);
  assign sacc_d = {OW{gte_w}} - val_i + sacc_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sacc_q <= '0;
      bit_o  <= 1'b0;
    end else if (clr_i) begin
      sacc_q <= '0;
      bit_o  <= 1'b0;
    end else if (mode_i == MODE_SDM) begin
      sacc_q <= sacc_d;
      bit_o  <= gte_w;
    end else begin
      bit_o  <= pwm_w;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sound_mixer.sv
`default_nettype none
// ==== sound_mixer: NCH-channel volume/pan mixer with stereo 1-bit outputs (rev 1.0) ====
module sound_mixer
  import sound_mixer_pkg::*;
#(
  parameter int NCH = 4,
  parameter int DW  = 8,
  parameter int VW  = 4,
  parameter int OW  = 10
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [DW-1:0]          din_i,
  input  logic [NCH-1:0]         ch_wr_i,
  input  logic                   cfg_wr_i,
  input  logic [$clog2(NCH)-1:0] cfg_ch_i,
  input  logic                   beeper_wr_i,
  input  logic                   beeper_mux_i,
  input  logic                   tape_sound_i,
  input  logic                   tape_in_i,
  input  logic                   mode_i,
  output logic                   sound_l_o,
  output logic                   sound_r_o,
  output logic                   sample_tick_o
);

  localparam int LW = $clog2(NCH);
  localparam int PW = DW + VW;
  localparam int SW = DW + VW + LW;
  localparam logic [DW-1:0] TAPE_LVL   = {TAPE_LVL_MSB, {(DW-1){TAPE_LVL_LSBS}}};
  localparam logic [LW-1:0] IDX_LAST   = LW'(NCH - 1);
  localparam logic [LW-1:0] IDX_ONE    = LW'(1);
  localparam logic [OW:0]   PCTR_ONE   = (OW+1)'(1);

  logic [DW-1:0]  ch_q   [NCH];
  logic [DW-1:0]  ch_d   [NCH];
  logic [VW-1:0]  vol_q  [NCH];
  logic [VW-1:0]  vol_d  [NCH];
  logic [NCH-1:0] pan_l_q, pan_l_d;
  logic [NCH-1:0] pan_r_q, pan_r_d;

  logic           beep_bit_w;
  logic [DW-1:0]  beep_lvl_w;

  assign beep_bit_w = beeper_mux_i ? din_i[3] : din_i[4];
  assign beep_lvl_w = {DW{beep_bit_w}};

  always_comb begin
    ch_d    = ch_q;
    vol_d   = vol_q;
    pan_l_d = pan_l_q;
    pan_r_d = pan_r_q;
    for (int i = 1; i < NCH; i++) begin
      if (ch_wr_i[i]) ch_d[i] = din_i;
    end
    // Channel 0 doubles as the legacy beeper/tape sink; tape follows the input level
    if (ch_wr_i[0])        ch_d[0] = din_i;
    else if (tape_sound_i) ch_d[0] = tape_in_i ? TAPE_LVL : '0;
    else if (beeper_wr_i)  ch_d[0] = beep_lvl_w;
    if (cfg_wr_i) begin
      vol_d[cfg_ch_i]   = din_i[VW-1:0];
      pan_r_d[cfg_ch_i] = din_i[VW + CFG_PAN_R_OFS];
      pan_l_d[cfg_ch_i] = din_i[VW + CFG_PAN_L_OFS];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NCH; i++) begin
        ch_q[i]  <= '0;
        vol_q[i] <= '1;
      end
      pan_l_q <= '1;
      pan_r_q <= '1;
    end else begin
      ch_q    <= ch_d;
      vol_q   <= vol_d;
      pan_l_q <= pan_l_d;
      pan_r_q <= pan_r_d;
    end
  end

  logic [LW-1:0]  idx_q;
  logic [SW-1:0]  acc_l_q, acc_r_q;
  logic [OW-1:0]  hold_l_q, hold_r_q;
  logic [PW-1:0]  prod_w;
  logic [SW-1:0]  sum_l_w, sum_r_w;
  logic           last_w;

  assign prod_w  = PW'(ch_q[idx_q]) * PW'(vol_q[idx_q]);
  assign sum_l_w = acc_l_q + (pan_l_q[idx_q] ? SW'(prod_w) : '0);
  assign sum_r_w = acc_r_q + (pan_r_q[idx_q] ? SW'(prod_w) : '0);
  assign last_w  = (idx_q == IDX_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q    <= '0;
      acc_l_q  <= '0;
      acc_r_q  <= '0;
      hold_l_q <= '0;
      hold_r_q <= '0;
    end else if (last_w) begin
      idx_q    <= '0;
      acc_l_q  <= '0;
      acc_r_q  <= '0;
      hold_l_q <= sum_l_w[SW-1 -: OW];
      hold_r_q <= sum_r_w[SW-1 -: OW];
    end else begin
      idx_q    <= idx_q + IDX_ONE;
      acc_l_q  <= sum_l_w;
      acc_r_q  <= sum_r_w;
    end
  end

  logic [OW:0]   pctr_q;
  logic [OW-1:0] val_l_q, val_r_q;
  logic          mode_q;
  logic          tick_w;
  logic          clr_w;

  assign tick_w = (pctr_q == '0);
  // A mode switch restarts both integrators from zero on the boundary it lands on
  assign clr_w  = tick_w && (mode_i != mode_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pctr_q        <= '0;
      val_l_q       <= '0;
      val_r_q       <= '0;
      mode_q        <= MODE_PWM;
      sample_tick_o <= 1'b0;
    end else begin
      pctr_q        <= pctr_q + PCTR_ONE;
      sample_tick_o <= tick_w;
      if (tick_w) begin
        val_l_q <= hold_l_q;
        val_r_q <= hold_r_q;
        mode_q  <= mode_i;
      end
    end
  end

  sound_mod #(.OW(OW)) u_mod_l (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .val_i  (val_l_q),
    .mode_i (mode_q),
    .pctr_i (pctr_q),
    .clr_i  (clr_w),
    .bit_o  (sound_l_o)
  );

  sound_mod #(.OW(OW)) u_mod_r (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .val_i  (val_r_q),
    .mode_i (mode_q),
    .pctr_i (pctr_q),
    .clr_i  (clr_w),
    .bit_o  (sound_r_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_sound_mixer.sv
`default_nettype none
// ==== tb_sound_mixer: directed self-checking bench for sound_mixer (rev 1.0) ====
module tb_sound_mixer;

  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int VW  = 4;
  localparam int OW  = 10;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [DW-1:0]  din;
  logic [NCH-1:0] ch_wr;
  logic           cfg_wr;
  logic [1:0]     cfg_ch;
  logic           beeper_wr, beeper_mux, tape_sound, tape_in, mode;
  logic           sound_l, sound_r, sample_tick;

  int n_checks = 0;
  int n_err    = 0;
  int hl, hr;

  always #5 clk = ~clk;

  sound_mixer #(.NCH(NCH), .DW(DW), .VW(VW), .OW(OW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .din_i        (din),
    .ch_wr_i      (ch_wr),
    .cfg_wr_i     (cfg_wr),
    .cfg_ch_i     (cfg_ch),
    .beeper_wr_i  (beeper_wr),
    .beeper_mux_i (beeper_mux),
    .tape_sound_i (tape_sound),
    .tape_in_i    (tape_in),
    .mode_i       (mode),
    .sound_l_o    (sound_l),
    .sound_r_o    (sound_r),
    .sample_tick_o(sample_tick)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
    n_checks++;
    assert (obs >= lo && obs <= hi) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic wr_ch(input int i, input logic [7:0] d);
    @(negedge clk); ch_wr = NCH'(1) << i; din = d;
    @(negedge clk); ch_wr = '0;
  endtask

  task automatic wr_cfg(input int i, input logic [7:0] d);
    @(negedge clk); cfg_wr = 1'b1; cfg_ch = 2'(i); din = d;
    @(negedge clk); cfg_wr = 1'b0;
  endtask

  task automatic settle;
    repeat (2*NCH+2) @(negedge clk);
  endtask

  task automatic wait_tick;
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (sample_tick !== 1'b1 && n < 4200);
    check("tick_seen", 32'(sample_tick), 1);
  endtask

  task automatic count_hi(input int n, output int cl, output int cr);
    cl = 0; cr = 0;
    repeat (n) begin
      @(negedge clk);
      cl = cl + int'(sound_l);
      cr = cr + int'(sound_r);
    end
  endtask

  initial begin
    rst_n = 1'b0; din = '0; ch_wr = '0; cfg_wr = 1'b0; cfg_ch = '0;
    beeper_wr = 1'b0; beeper_mux = 1'b0; tape_sound = 1'b0; tape_in = 1'b0; mode = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_sound_l", 32'(sound_l), 0);
    check("rst_sound_r", 32'(sound_r), 0);
    check("rst_tick", 32'(sample_tick), 0);
    check("rst_vol2", 32'(dut.vol_q[2]), 15);
    check("rst_pan_l", 32'(dut.pan_l_q), 32'hF);
    check("rst_ch0", 32'(dut.ch_q[0]), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_tick", 32'(sample_tick), 1);
    @(negedge clk);
    check("tick_one_cycle", 32'(sample_tick), 0);

    // Single full-scale channel
    wr_ch(0, 8'hFF);
    settle();
    check("hold_l_ch0", 32'(dut.hold_l_q), 239);
    check("hold_r_ch0", 32'(dut.hold_r_q), 239);
    wait_tick();
    count_hi(2048, hl, hr);
    check("pwm_l_239", hl, 478);
    check("pwm_r_239", hr, 478);

    // All channels full-scale
    wr_ch(1, 8'hFF); wr_ch(2, 8'hFF); wr_ch(3, 8'hFF);
    settle();
    check("hold_l_all", 32'(dut.hold_l_q), 956);
    wait_tick();
    count_hi(2048, hl, hr);
    check("pwm_l_956", hl, 1912);
    check("pwm_r_956", hr, 1912);

    // Left-only pan on channel 1
    wr_ch(0, 8'h00); wr_ch(2, 8'h00); wr_ch(3, 8'h00);
    wr_cfg(1, 8'h2F);
    wr_ch(1, 8'h80);
    settle();
    check("hold_l_pan", 32'(dut.hold_l_q), 120);
    check("hold_r_pan", 32'(dut.hold_r_q), 0);
    wait_tick();
    count_hi(2048, hl, hr);
    check("pwm_l_120", hl, 240);
    check("pwm_r_zero", hr, 0);

    // Tape beats beeper; explicit write beats tape
    @(negedge clk);
    tape_sound = 1'b1; tape_in = 1'b1; beeper_wr = 1'b1; beeper_mux = 1'b0; din = 8'h10;
    @(negedge clk);
    beeper_wr = 1'b0;
    check("tape_over_beep", 32'(dut.ch_q[0]), 32'h7F);
    settle();
    check("hold_r_tape", 32'(dut.hold_r_q), 119);
    check("hold_l_tape", 32'(dut.hold_l_q), 239);
    ch_wr = 4'b0001; din = 8'h10;
    @(negedge clk);
    ch_wr = '0; tape_sound = 1'b0;
    check("wr_over_tape", 32'(dut.ch_q[0]), 32'h10);
    @(negedge clk);
    check("ch0_kept", 32'(dut.ch_q[0]), 32'h10);
    beeper_wr = 1'b1; beeper_mux = 1'b1; din = 8'h08;
    @(negedge clk);
    check("beep_din3", 32'(dut.ch_q[0]), 32'hFF);
    beeper_mux = 1'b0;
    @(negedge clk);
    beeper_wr = 1'b0;
    check("beep_din4", 32'(dut.ch_q[0]), 0);

    // Sigma-delta at val = 512: (3825+3825+0x44*8)>>4 = 8194>>4
    wr_cfg(1, 8'h3F); wr_cfg(2, 8'h38);
    wr_ch(0, 8'hFF); wr_ch(1, 8'hFF); wr_ch(2, 8'h44); wr_ch(3, 8'h00);
    settle();
    check("hold_l_512", 32'(dut.hold_l_q), 512);
    check("hold_r_512", 32'(dut.hold_r_q), 512);
    mode = 1'b1;
    wait_tick();
    check("sdm_mode", 32'(dut.mode_q), 1);
    check("sacc_l_clr", 32'(dut.u_mod_l.sacc_q), 0);
    check("sacc_r_clr", 32'(dut.u_mod_r.sacc_q), 0);
    count_hi(1024, hl, hr);
    check_rng("sdm_l_512", hl, 511, 513);
    check_rng("sdm_r_512", hr, 511, 513);
    count_hi(1024, hl, hr);
    check_rng("sdm_l_512b", hl, 511, 513);

    wr_ch(0, 8'h00); wr_ch(1, 8'h00); wr_ch(2, 8'h00);
    settle();
    check("hold_l_zero", 32'(dut.hold_l_q), 0);
    wait_tick();
    @(negedge clk);
    count_hi(1024, hl, hr);
    check("sdm_l_zero", hl, 0);
    check("sdm_r_zero", hr, 0);

    // Async reset mid-period after a PWM setup; ch2 vol is 8 here
    mode = 1'b0;
    wr_ch(0, 8'hFF); wr_ch(1, 8'hFF); wr_ch(2, 8'hFF); wr_ch(3, 8'hFF);
    settle();
    check("hold_l_844", 32'(dut.hold_l_q), 844);
    wait_tick();
    check("pwm_mode_back", 32'(dut.mode_q), 0);
    repeat (600) @(negedge clk);
    check("pre_rst_l", 32'(sound_l), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_sound_l", 32'(sound_l), 0);
    check("async_sound_r", 32'(sound_r), 0);
    check("async_vol2", 32'(dut.vol_q[2]), 15);
    check("async_hold", 32'(dut.hold_l_q), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("tick_after_rel", 32'(sample_tick), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
